ahbl_arb2: RTL and testbench

AHBL_ARB2 -- requirements
Module: ahbl_arb2

---
 rtl/ahbl_arb2.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_ahbl_arb2.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_arb2.sv
//------------------------------------------------------------------------------
// ahbl_arb2 -- two-master to one-slave AHB-Lite arbiter.
//
// Two AHB-Lite masters share one AHB-Lite slave. There are no bus-request
// lines: an address phase that loses arbitration (or arrives while the slave
// is stalling) is captured into a per-master pending register, and the master
// is stalled through its HREADY until that pending transfer has been issued.
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   Mx_HTRANS/HADDR/HWRITE/HSIZE/HWDATA   master x address/data inputs (x=0,1)
//   Mx_HREADY/HRESP/HRDATA                responses returned to master x
//   S_HSEL/HTRANS/HADDR/HWRITE/HSIZE/HWDATA  slave-side AHB-Lite master port
//   S_HREADY                equals S_HREADYOUT
//   S_HREADYOUT/HRESP/HRDATA  slave ready, response and read data
//
// Configuration
//   AHBL_ARB2_FIXED_PRIO_EN  defined: M0 always wins contention.
//                            undefined: round-robin, M0 first after reset.
//------------------------------------------------------------------------------
module ahbl_arb2 (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [1:0]  M0_HTRANS,
   input  logic [31:0] M0_HADDR,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic [31:0] M0_HWDATA,
   output logic        M0_HREADY,
   output logic        M0_HRESP,
   output logic [31:0] M0_HRDATA,
   input  logic [1:0]  M1_HTRANS,
   input  logic [31:0] M1_HADDR,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic [31:0] M1_HWDATA,
   output logic        M1_HREADY,
   output logic        M1_HRESP,
   output logic [31:0] M1_HRDATA,
   output logic        S_HSEL,
   output logic [1:0]  S_HTRANS,
   output logic [31:0] S_HADDR,
   output logic        S_HWRITE,
   output logic [2:0]  S_HSIZE,
   output logic [31:0] S_HWDATA,
   output logic        S_HREADY,
   input  logic        S_HREADYOUT,
   input  logic        S_HRESP,
   input  logic [31:0] S_HRDATA
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   owner_e      owner_q, owner_d;
   logic        pend0_q, pend0_d;
   logic        pend1_q, pend1_d;

   logic [1:0]  p0_trans_q, p0_trans_d;
   logic [31:0] p0_addr_q,  p0_addr_d;
   logic        p0_write_q, p0_write_d;
   logic [2:0]  p0_size_q,  p0_size_d;
   logic [1:0]  p1_trans_q, p1_trans_d;
   logic [31:0] p1_addr_q,  p1_addr_d;
   logic        p1_write_q, p1_write_d;
   logic [2:0]  p1_size_q,  p1_size_d;

   logic        m0_rdy, m1_rdy;
   logic        new_req0, new_req1;
   logic        act0, act1;
   logic        gnt0, gnt1;
   logic        m1_first;

   logic [1:0]  sel_trans;
   logic [31:0] sel_addr;
   logic        sel_write;
   logic [2:0]  sel_size;

   //---------------------------------------------------------------------------
   // Arbitration policy
   //---------------------------------------------------------------------------
`ifdef AHBL_ARB2_FIXED_PRIO_EN
   assign m1_first = 1'b0;
`else
   // prio_q=1 means M1 wins the next contention (M0 was granted last).
   logic prio_q, prio_d;

   always_comb begin
      prio_d = prio_q;
      if (gnt0) begin
         prio_d = 1'b1;
      end else if (gnt1) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign m1_first = prio_q;
`endif

   //---------------------------------------------------------------------------
   // Ready, request detection and grant
   //---------------------------------------------------------------------------
   always_comb begin
      m0_rdy = 1'b1;
      m1_rdy = 1'b1;
      if (!HRESET) begin
         m0_rdy = !(pend0_q || ((owner_q == OWN_M0) && !S_HREADYOUT));
         m1_rdy = !(pend1_q || ((owner_q == OWN_M1) && !S_HREADYOUT));
      end
   end

   // A master's address phase only counts when it sees HREADY high, so a
   // master stalled behind its own data phase becomes eligible in the very
   // cycle that data phase completes.
   assign new_req0 = M0_HTRANS[1] && m0_rdy && !HRESET;
   assign new_req1 = M1_HTRANS[1] && m1_rdy && !HRESET;
   assign act0     = pend0_q || new_req0;
   assign act1     = pend1_q || new_req1;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      // Granting only while the slave is ready keeps NONSEQ off the bus
      // during slave wait states.
      if (!HRESET && S_HREADYOUT) begin
         if (act0 && act1) begin
            if (m1_first) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end else if (act0) begin
            gnt0 = 1'b1;
         end else if (act1) begin
            gnt1 = 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Slave address phase: pending copy takes precedence over live inputs
   //---------------------------------------------------------------------------
   always_comb begin
      sel_trans = HTRANS_IDLE;
      sel_addr  = 32'd0;
      sel_write = 1'b0;
      sel_size  = 3'd0;
      if (gnt0) begin
         if (pend0_q) begin
            sel_trans = p0_trans_q;
            sel_addr  = p0_addr_q;
            sel_write = p0_write_q;
            sel_size  = p0_size_q;
         end else begin
            sel_trans = M0_HTRANS;
            sel_addr  = M0_HADDR;
            sel_write = M0_HWRITE;
            sel_size  = M0_HSIZE;
         end
      end else if (gnt1) begin
         if (pend1_q) begin
            sel_trans = p1_trans_q;
            sel_addr  = p1_addr_q;
            sel_write = p1_write_q;
            sel_size  = p1_size_q;
         end else begin
            sel_trans = M1_HTRANS;
            sel_addr  = M1_HADDR;
            sel_write = M1_HWRITE;
            sel_size  = M1_HSIZE;
         end
      end
   end

   // The slave sees a fresh arbitration each time, so a granted SEQ is
   // presented as NONSEQ by clearing bit 0; no grant leaves IDLE.
   assign S_HSEL   = gnt0 || gnt1;
   assign S_HTRANS = sel_trans & HTRANS_NONSEQ;
   assign S_HADDR  = sel_addr;
   assign S_HWRITE = sel_write;
   assign S_HSIZE  = sel_size;
   assign S_HREADY = S_HREADYOUT;

   //---------------------------------------------------------------------------
   // Data phase routing
   //---------------------------------------------------------------------------
   always_comb begin
      case (owner_q)
         OWN_M0:  S_HWDATA = M0_HWDATA;
         OWN_M1:  S_HWDATA = M1_HWDATA;
         default: S_HWDATA = 32'd0;
      endcase
   end

   assign M0_HREADY = m0_rdy;
   assign M1_HREADY = m1_rdy;
   assign M0_HRESP  = !HRESET && (owner_q == OWN_M0) && S_HRESP;
   assign M1_HRESP  = !HRESET && (owner_q == OWN_M1) && S_HRESP;
   assign M0_HRDATA = S_HRDATA;
   assign M1_HRDATA = S_HRDATA;

   //---------------------------------------------------------------------------
   // Next state: pending flags, captured address phase, data-phase owner
   //---------------------------------------------------------------------------
   always_comb begin
      pend0_d = pend0_q;
      pend1_d = pend1_q;
      if (gnt0) begin
         pend0_d = 1'b0;
      end else if (new_req0) begin
         pend0_d = 1'b1;
      end
      if (gnt1) begin
         pend1_d = 1'b0;
      end else if (new_req1) begin
         pend1_d = 1'b1;
      end

      owner_d = owner_q;
      if (S_HREADYOUT) begin
         if (gnt0) begin
            owner_d = OWN_M0;
         end else if (gnt1) begin
            owner_d = OWN_M1;
         end else begin
            owner_d = OWN_NONE;
         end
      end
   end

   always_comb begin
      p0_trans_d = p0_trans_q;
      p0_addr_d  = p0_addr_q;
      p0_write_d = p0_write_q;
      p0_size_d  = p0_size_q;
      p1_trans_d = p1_trans_q;
      p1_addr_d  = p1_addr_q;
      p1_write_d = p1_write_q;
      p1_size_d  = p1_size_q;
      if (new_req0 && !gnt0) begin
         p0_trans_d = M0_HTRANS;
         p0_addr_d  = M0_HADDR;
         p0_write_d = M0_HWRITE;
         p0_size_d  = M0_HSIZE;
      end
      if (new_req1 && !gnt1) begin
         p1_trans_d = M1_HTRANS;
         p1_addr_d  = M1_HADDR;
         p1_write_d = M1_HWRITE;
         p1_size_d  = M1_HSIZE;
      end
   end

   //---------------------------------------------------------------------------
   // Registers: control is reset, captured address fields are not
   //---------------------------------------------------------------------------
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         pend0_q <= 1'b0;
         pend1_q <= 1'b0;
         owner_q <= OWN_NONE;
      end else begin
         pend0_q <= pend0_d;
         pend1_q <= pend1_d;
         owner_q <= owner_d;
      end
   end

   always_ff @(posedge HCLK) begin
      p0_trans_q <= p0_trans_d;
      p0_addr_q  <= p0_addr_d;
      p0_write_q <= p0_write_d;
      p0_size_q  <= p0_size_d;
      p1_trans_q <= p1_trans_d;
      p1_addr_q  <= p1_addr_d;
      p1_write_q <= p1_write_d;
      p1_size_q  <= p1_size_d;
   end

endmodule

// File: tb/tb_ahbl_arb2.sv
//------------------------------------------------------------------------------
// tb_ahbl_arb2 -- self-checking bench for ahbl_arb2.
// Directed cycle table, a hand-written back-to-back sequence, then random
// masters/slave checked against a transaction-level reference model.
//------------------------------------------------------------------------------
module tb_ahbl_arb2;

`ifdef AHBL_ARB2_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] NS = 2'b10;
   localparam logic [31:0] WA = 32'hAAAA_0000;
   localparam logic [31:0] WB = 32'hBBBB_0000;

   logic        HCLK = 1'b0;
   logic        rst;
   logic [1:0]  t  [2];
   logic [31:0] a  [2];
   logic        w  [2];
   logic [2:0]  s  [2];
   logic [31:0] wd [2];
   logic        hro, hresp;
   logic [31:0] rdata;

   logic        M0_HREADY, M0_HRESP, M1_HREADY, M1_HRESP;
   logic [31:0] M0_HRDATA, M1_HRDATA;
   logic        S_HSEL, S_HWRITE, S_HREADY;
   logic [1:0]  S_HTRANS;
   logic [31:0] S_HADDR, S_HWDATA;
   logic [2:0]  S_HSIZE;

   always #5 HCLK = ~HCLK;

   ahbl_arb2 dut (
      .HCLK(HCLK), .HRESET(rst),
      .M0_HTRANS(t[0]), .M0_HADDR(a[0]), .M0_HWRITE(w[0]), .M0_HSIZE(s[0]),
      .M0_HWDATA(wd[0]), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
      .M1_HTRANS(t[1]), .M1_HADDR(a[1]), .M1_HWRITE(w[1]), .M1_HSIZE(s[1]),
      .M1_HWDATA(wd[1]), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
      .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE),
      .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
      .S_HREADYOUT(hro), .S_HRESP(hresp), .S_HRDATA(rdata)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Directed vector table: one row = one clock cycle
   //---------------------------------------------------------------------------
   typedef struct {
      logic        rst;
      logic [1:0]  t0;  logic [31:0] a0; logic w0;
      logic [1:0]  t1;  logic [31:0] a1; logic w1;
      logic        hro; logic hresp; logic [31:0] rdata;
      logic [31:0] wd0; logic [31:0] wd1;
      logic        r0, r1, rs0, rs1, sel;
      logic [1:0]  strans; logic [31:0] saddr; logic swrite; logic [2:0] ssize;
      logic [31:0] swdata;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic rst_i,
                    input logic [1:0] t0, input logic [31:0] a0, input logic w0,
                    input logic [1:0] t1, input logic [31:0] a1, input logic w1,
                    input logic hro_i, input logic hresp_i, input logic [31:0] rd,
                    input logic [31:0] wd0, input logic [31:0] wd1,
                    input logic r0, input logic r1, input logic rs0, input logic rs1,
                    input logic sel, input logic [1:0] st, input logic [31:0] sa,
                    input logic sw, input logic [2:0] ss, input logic [31:0] swd);
      vec_t x;
      x.rst = rst_i; x.t0 = t0; x.a0 = a0; x.w0 = w0; x.t1 = t1; x.a1 = a1; x.w1 = w1;
      x.hro = hro_i; x.hresp = hresp_i; x.rdata = rd; x.wd0 = wd0; x.wd1 = wd1;
      x.r0 = r0; x.r1 = r1; x.rs0 = rs0; x.rs1 = rs1; x.sel = sel; x.strans = st;
      x.saddr = sa; x.swrite = sw; x.ssize = ss; x.swdata = swd;
      vecs.push_back(x);
   endtask

   task automatic fill_table();
      // reset with M1 requesting: outputs forced quiet
      v(1, ID,0,0, NS,32'h99,1, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, 0);
      // single M0 write, zero-wait slave
      v(0, NS,32'h10,1, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 1,NS,32'h10,1,2, 0);
      v(0, ID,0,0, ID,0,0, 1,0,0, 32'hA5A5_0001,WB, 1,1,0,0, 0,ID,0,0,0, 32'hA5A5_0001);
      v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, 0);
      // reset, then collision
      v(1, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, 0);
      v(0, NS,32'h100,0, NS,32'h200,1, 1,0,0, WA,WB, 1,1,0,0, 1,NS,32'h100,0,2, 0);
      if (FIXED) begin
         v(0, NS,32'h104,0, NS,32'h200,1, 1,0,0, WA,WB, 1,0,0,0, 1,NS,32'h104,0,2, WA);
         v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,0,0,0, 1,NS,32'h200,1,1, WA);
         v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, WB);
      end else begin
         v(0, NS,32'h104,0, NS,32'h200,1, 1,0,0, WA,WB, 1,0,0,0, 1,NS,32'h200,1,1, WA);
         v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 0,1,0,0, 1,NS,32'h104,0,2, WB);
         v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, WA);
      end
      v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, 0);
      // M0 read with two wait states, M1 request held pending meanwhile
      v(0, NS,32'h300,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 1,NS,32'h300,0,2, 0);
      v(0, ID,0,0, NS,32'h400,1, 0,0,0, WA,WB, 0,1,0,0, 0,ID,0,0,0, WA);
      v(0, ID,0,0, ID,0,0, 0,0,0, WA,WB, 0,0,0,0, 0,ID,0,0,0, WA);
      v(0, ID,0,0, ID,0,0, 1,0,32'h1234_5678, WA,WB, 1,0,0,0, 1,NS,32'h400,1,1, WA);
      v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, WB);
      // two-cycle ERROR to M1
      v(0, ID,0,0, NS,32'h500,0, 1,0,0, WA,WB, 1,1,0,0, 1,NS,32'h500,0,1, 0);
      v(0, ID,0,0, ID,0,0, 0,1,0, WA,WB, 1,0,0,1, 0,ID,0,0,0, WB);
      v(0, ID,0,0, ID,0,0, 1,1,0, WA,WB, 1,1,0,1, 0,ID,0,0,0, WB);
      v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, 0);
      // reset while M1 pending
      v(0, NS,32'h600,1, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 1,NS,32'h600,1,2, 0);
      v(0, ID,0,0, NS,32'h700,1, 0,0,0, WA,WB, 0,1,0,0, 0,ID,0,0,0, WA);
      v(0, ID,0,0, ID,0,0, 0,0,0, WA,WB, 0,0,0,0, 0,ID,0,0,0, WA);
      v(1, ID,0,0, ID,0,0, 0,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, WA);
      v(0, ID,0,0, ID,0,0, 1,0,0, WA,WB, 1,1,0,0, 0,ID,0,0,0, 0);
   endtask

   //---------------------------------------------------------------------------
   // Reference model: pending records, owner index (-1 = none), last grantee
   //---------------------------------------------------------------------------
   int          own;
   int          last;
   bit          pv [2];
   logic [31:0] pa [2];
   logic        pw [2];
   logic [2:0]  ps [2];
   bit          prev_rdy [2];

   task automatic model_cycle();
      bit rdy [2];
      bit nr  [2];
      bit act [2];
      int g;
      logic [31:0] ea, ewd;
      logic ew;
      logic [2:0] es;
      for (int x = 0; x < 2; x++) begin
         rdy[x] = rst || !(pv[x] || (own == x && !hro));
         nr[x]  = !rst && t[x][1] && rdy[x];
         act[x] = pv[x] || nr[x];
      end
      g = -1;
      if (!rst && hro) begin
         if (act[0] && act[1]) g = FIXED ? 0 : 1 - last;
         else if (act[0])      g = 0;
         else if (act[1])      g = 1;
      end
      ea = 0; ew = 0; es = 0;
      if (g >= 0) begin
         if (pv[g]) begin ea = pa[g]; ew = pw[g]; es = ps[g]; end
         else       begin ea = a[g];  ew = w[g];  es = s[g];  end
      end
      ewd = (own == 0) ? wd[0] : (own == 1) ? wd[1] : 32'd0;

      chk("rnd m0_hready", M0_HREADY, rdy[0]);
      chk("rnd m1_hready", M1_HREADY, rdy[1]);
      chk("rnd m0_hresp",  M0_HRESP, (!rst && own == 0) ? hresp : 1'b0);
      chk("rnd m1_hresp",  M1_HRESP, (!rst && own == 1) ? hresp : 1'b0);
      chk("rnd m0_hrdata", M0_HRDATA, rdata);
      chk("rnd m1_hrdata", M1_HRDATA, rdata);
      chk("rnd s_hsel",    S_HSEL, g >= 0);
      chk("rnd s_htrans",  S_HTRANS, (g >= 0) ? NS : ID);
      chk("rnd s_haddr",   S_HADDR, ea);
      chk("rnd s_hwrite",  S_HWRITE, ew);
      chk("rnd s_hsize",   S_HSIZE, es);
      chk("rnd s_hwdata",  S_HWDATA, ewd);
      chk("rnd s_hready",  S_HREADY, hro);

      // state after the coming rising edge
      for (int x = 0; x < 2; x++) prev_rdy[x] = rdy[x];
      if (rst) begin
         pv[0] = 0; pv[1] = 0; own = -1; last = 1;
      end else begin
         for (int x = 0; x < 2; x++) begin
            if (g == x) pv[x] = 0;
            else if (nr[x]) begin pv[x] = 1; pa[x] = a[x]; pw[x] = w[x]; ps[x] = s[x]; end
         end
         if (hro) own = g;
         if (g >= 0) last = g;
      end
   endtask

   task automatic set_idle();
      for (int x = 0; x < 2; x++) begin t[x] = ID; a[x] = 0; w[x] = 0; end
      s[0] = 3'd2; s[1] = 3'd1;
      wd[0] = WA; wd[1] = WB;
      hro = 1; hresp = 0; rdata = 0;
   endtask

   initial begin
      rst = 1;
      set_idle();
      fill_table();
      repeat (2) @(posedge HCLK);

      foreach (vecs[i]) begin
         @(negedge HCLK);
         rst = vecs[i].rst;
         t[0] = vecs[i].t0; a[0] = vecs[i].a0; w[0] = vecs[i].w0;
         t[1] = vecs[i].t1; a[1] = vecs[i].a1; w[1] = vecs[i].w1;
         hro = vecs[i].hro; hresp = vecs[i].hresp; rdata = vecs[i].rdata;
         wd[0] = vecs[i].wd0; wd[1] = vecs[i].wd1;
         #1;
         chk($sformatf("row%0d m0_hready", i), M0_HREADY, vecs[i].r0);
         chk($sformatf("row%0d m1_hready", i), M1_HREADY, vecs[i].r1);
         chk($sformatf("row%0d m0_hresp", i),  M0_HRESP, vecs[i].rs0);
         chk($sformatf("row%0d m1_hresp", i),  M1_HRESP, vecs[i].rs1);
         chk($sformatf("row%0d m0_hrdata", i), M0_HRDATA, vecs[i].rdata);
         chk($sformatf("row%0d m1_hrdata", i), M1_HRDATA, vecs[i].rdata);
         chk($sformatf("row%0d s_hsel", i),    S_HSEL, vecs[i].sel);
         chk($sformatf("row%0d s_htrans", i),  S_HTRANS, vecs[i].strans);
         chk($sformatf("row%0d s_haddr", i),   S_HADDR, vecs[i].saddr);
         chk($sformatf("row%0d s_hwrite", i),  S_HWRITE, vecs[i].swrite);
         chk($sformatf("row%0d s_hsize", i),   S_HSIZE, vecs[i].ssize);
         chk($sformatf("row%0d s_hwdata", i),  S_HWDATA, vecs[i].swdata);
         chk($sformatf("row%0d s_hready", i),  S_HREADY, vecs[i].hro);
      end

      // M0 data phase stalls, then completes in the same cycle M0's next
      // (held) request becomes visible: that request is granted at once.
      @(negedge HCLK);
      set_idle(); rst = 0;
      t[0] = NS; a[0] = 32'h800; w[0] = 1;
      #1;
      chk("b2b grant1 sel", S_HSEL, 1);
      chk("b2b grant1 addr", S_HADDR, 32'h800);
      @(negedge HCLK);
      a[0] = 32'h804; hro = 0;
      #1;
      chk("b2b stall m0_hready", M0_HREADY, 0);
      chk("b2b stall sel", S_HSEL, 0);
      chk("b2b stall htrans", S_HTRANS, ID);
      @(negedge HCLK);
      hro = 1; wd[0] = 32'hC0DE_0800;
      #1;
      chk("b2b done m0_hready", M0_HREADY, 1);
      chk("b2b grant2 sel", S_HSEL, 1);
      chk("b2b grant2 addr", S_HADDR, 32'h804);
      chk("b2b wdata1", S_HWDATA, 32'hC0DE_0800);
      @(negedge HCLK);
      t[0] = ID; wd[0] = 32'hC0DE_0804;
      #1;
      chk("b2b idle sel", S_HSEL, 0);
      chk("b2b wdata2", S_HWDATA, 32'hC0DE_0804);

      // random phase, starting from a clean reset
      @(negedge HCLK);
      set_idle(); rst = 1;
      own = -1; last = 1; pv[0] = 0; pv[1] = 0;
      prev_rdy[0] = 1; prev_rdy[1] = 1;
      for (int x = 0; x < 2; x++) begin pa[x] = 0; pw[x] = 0; ps[x] = 0; end
      for (int i = 0; i < 2000; i++) begin
         @(negedge HCLK);
         rst = (i < 2) || ($urandom_range(0, 99) == 0);
         for (int x = 0; x < 2; x++) begin
            if (prev_rdy[x]) begin
               case ($urandom_range(0, 7))
                  0, 1, 2: t[x] = 2'b00;
                  3, 4, 5: t[x] = 2'b10;
                  6:       t[x] = 2'b11;
                  default: t[x] = 2'b01;
               endcase
               a[x] = $urandom;
               w[x] = 1'($urandom_range(0, 1));
               s[x] = 3'($urandom_range(0, 7));
            end
            wd[x] = $urandom;
         end
         hro   = ($urandom_range(0, 3) != 0);
         hresp = ($urandom_range(0, 7) == 0);
         rdata = $urandom;
         #1;
         model_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
